// File: rtl/fruit_pkg.sv
// Shared constants for the fruit launcher: screen geometry defaults,
// FSM state encodings and the LFSR seed/taps.
package fruit_pkg;

   localparam int SCREEN_W_DEF     = 640;
   localparam int SCREEN_H_DEF     = 480;
   localparam int FRUIT_SIZE_DEF   = 16;
   localparam int LAUNCH_DELAY_DEF = 30;
   localparam int VY_MIN_DEF       = 20;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_FLY       = 2'd1;
   localparam logic [1:0] ST_SLICED    = 2'd2;
   localparam logic [1:0] ST_GAME_OVER = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; the non-zero seed keeps it off the all-zero lockup state.
module lfsr16
   import fruit_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   output logic [15:0] q
);

   // Advance once per clock, reload the seed on reset.
   always_ff @(posedge Clk) begin
      if (Reset) q <= LFSR_SEED;
      else       q <= lfsr_next(q);
   end

endmodule

// File: rtl/fruit_launcher.sv
// Frame-paced fruit engine: launch, ballistic flight, blade hit test, BCD score and miss count.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | counting frame ticks until the next launch
// ST_FLY       | fruit in flight, blade can slice it, bottom exit is a miss
// ST_SLICED    | cut fruit falling, bottom exit returns to idle, no miss
// ST_GAME_OVER | third miss reached, everything frozen until reset
module fruit_launcher
   import fruit_pkg::*;
#(
   parameter int SCREEN_W     = SCREEN_W_DEF,
   parameter int SCREEN_H     = SCREEN_H_DEF,
   parameter int FRUIT_SIZE   = FRUIT_SIZE_DEF,
   parameter int LAUNCH_DELAY = LAUNCH_DELAY_DEF,
   parameter int VY_MIN       = VY_MIN_DEF
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       vs,
   input  logic [9:0] blade_x,
   input  logic [9:0] blade_y,
   input  logic       blade_active,
   output logic [9:0] fruitX,
   output logic [9:0] fruitY,
   output logic [9:0] fruitS,
   output logic       fruit_visible,
   output logic       fruit_sliced,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones,
   output logic [1:0] misses,
   output logic       game_over
);

   localparam logic signed [10:0] X_MAX      = 11'(SCREEN_W - FRUIT_SIZE);
   localparam logic signed [10:0] Y_LIMIT    = 11'(SCREEN_H);
   localparam logic [10:0]        SIZE_11    = 11'(FRUIT_SIZE);
   localparam logic [7:0]         DELAY_LAST = 8'(LAUNCH_DELAY - 1);
   localparam logic signed [7:0]  VY_MIN_8   = 8'(VY_MIN);

   logic               vs_s, vs_q, tick;
   logic [15:0]        r;
   logic               unused_r;
   logic [1:0]         state, state_n;
   logic [7:0]         delay_cnt, delay_cnt_n;
   logic signed [10:0] x, y, x_n, y_n;
   logic signed [3:0]  vx, vx_n;
   logic signed [7:0]  vy, vy_n;
   logic [3:0]         tens_n, ones_n;
   logic [1:0]         misses_n;

   logic signed [10:0] vx_ext, vy_ext, x_sum, x_step, y_step, launch_x;
   logic signed [3:0]  vx_step, launch_mag, launch_vx;
   logic signed [7:0]  launch_vy;
   logic [10:0]        fx, fy, bx, by;
   logic               hit, exit_bottom;

   lfsr16 u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .q     (r)
   );

   // r[12:11] take no part in the launch draw.
   assign unused_r = ^r[12:11];

   // vs is synchronised first; the tick fires for one clock after a sampled falling edge.
   assign tick   = vs_q & ~vs_s;
   assign fruitX = x[9:0];
   assign fruitY = y[9:0];
   assign fruitS = 10'(FRUIT_SIZE);

   // Motion step, wall bounce, bottom exit, hit test and launch draw.
   always_comb begin
      vy_ext  = {{3{vy[7]}}, vy};
      vx_ext  = {{7{vx[3]}}, vx};
      y_step  = y + vy_ext;
      x_sum   = x + vx_ext;
      x_step  = x_sum;
      vx_step = vx;
      if (x_sum < 11'sd0) begin
         x_step  = '0;
         vx_step = -vx;
      end else if (x_sum > X_MAX) begin
         x_step  = X_MAX;
         vx_step = -vx;
      end
      exit_bottom = (vy > 8'sd0) && (y_step >= Y_LIMIT);

      fx  = {1'b0, x[9:0]};
      fy  = {1'b0, y[9:0]};
      bx  = {1'b0, blade_x};
      by  = {1'b0, blade_y};
      hit = blade_active && (bx >= fx) && (bx < fx + SIZE_11)
                         && (by >= fy) && (by < fy + SIZE_11);

      launch_x   = 11'sd64 + $signed({2'b00, r[8:0]});
      launch_mag = $signed({2'b00, r[10:9]}) + 4'sd1;
      launch_vx  = (launch_x < 11'sd320) ? launch_mag : -launch_mag;
      launch_vy  = -($signed({5'b00000, r[15:13]}) + VY_MIN_8);
   end

   // Next game state, evaluated only on a frame tick.
   always_comb begin
      state_n     = state;
      delay_cnt_n = delay_cnt;
      x_n         = x;
      y_n         = y;
      vx_n        = vx;
      vy_n        = vy;
      tens_n      = score_tens;
      ones_n      = score_ones;
      misses_n    = misses;
      if (tick) begin
         case (state)
            ST_IDLE: begin
               if (delay_cnt == DELAY_LAST) begin
                  delay_cnt_n = '0;
                  x_n         = launch_x;
                  y_n         = Y_LIMIT;
                  vx_n        = launch_vx;
                  vy_n        = launch_vy;
                  state_n     = ST_FLY;
               end else begin
                  delay_cnt_n = delay_cnt + 8'd1;
               end
            end
            ST_FLY, ST_SLICED: begin
               x_n  = x_step;
               y_n  = y_step;
               vx_n = vx_step;
               vy_n = vy + 8'sd1;
               if (state == ST_FLY && hit) begin
                  // A hit on the exit tick still wins; the cut fruit leaves on the next tick.
                  state_n = ST_SLICED;
                  if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
                     if (score_ones == 4'd9) begin
                        ones_n = 4'd0;
                        tens_n = score_tens + 4'd1;
                     end else begin
                        ones_n = score_ones + 4'd1;
                     end
                  end
               end else if (exit_bottom) begin
                  if (state == ST_FLY) begin
                     misses_n = misses + 2'd1;
                     state_n  = (misses == 2'd2) ? ST_GAME_OVER : ST_IDLE;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_s          <= 1'b1;
         vs_q          <= 1'b1;
         state         <= ST_IDLE;
         delay_cnt     <= '0;
         x             <= '0;
         y             <= Y_LIMIT;
         vx            <= '0;
         vy            <= '0;
         score_tens    <= '0;
         score_ones    <= '0;
         misses        <= '0;
         fruit_visible <= 1'b0;
         fruit_sliced  <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         vs_s          <= vs;
         vs_q          <= vs_s;
         state         <= state_n;
         delay_cnt     <= delay_cnt_n;
         x             <= x_n;
         y             <= y_n;
         vx            <= vx_n;
         vy            <= vy_n;
         score_tens    <= tens_n;
         score_ones    <= ones_n;
         misses        <= misses_n;
         fruit_visible <= (state_n == ST_FLY) || (state_n == ST_SLICED);
         fruit_sliced  <= (state_n == ST_SLICED);
         game_over     <= (state_n == ST_GAME_OVER);
      end
   end

endmodule

// File: tb/tb_fruit_launcher.sv
// Scoreboard bench for fruit_launcher: a frame-level reference model predicts every tick.
module tb_fruit_launcher;

   localparam int SCR_H = 480;
   localparam int X_MAX = 624;
   localparam int SIZE  = 16;
   localparam int DELAY = 30;

   localparam int M_WAIT = 0;
   localparam int M_FLY  = 1;
   localparam int M_FALL = 2;
   localparam int M_OVER = 3;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       vs = 1'b1;
   logic [9:0] blade_x = '0;
   logic [9:0] blade_y = '0;
   logic       blade_active = 1'b0;
   logic [9:0] fruitX, fruitY, fruitS;
   logic       fruit_visible, fruit_sliced, game_over;
   logic [3:0] score_tens, score_ones;
   logic [1:0] misses;

   fruit_launcher dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .vs            (vs),
      .blade_x       (blade_x),
      .blade_y       (blade_y),
      .blade_active  (blade_active),
      .fruitX        (fruitX),
      .fruitY        (fruitY),
      .fruitS        (fruitS),
      .fruit_visible (fruit_visible),
      .fruit_sliced  (fruit_sliced),
      .score_tens    (score_tens),
      .score_ones    (score_ones),
      .misses        (misses),
      .game_over     (game_over)
   );

   always #10 Clk = ~Clk;

   typedef struct {
      int x; int y; int vis; int sl; int tens; int ones; int miss; int go;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   int m_mode, m_wait, m_x, m_y, m_vx, m_vy, m_score, m_miss;
   int m_hits = 0;
   logic [15:0] m_lfsr = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Reference copy of the random source, one step per clock.
   always @(posedge Clk) begin
      if (Reset) m_lfsr = 16'hACE1;
      else       m_lfsr = lfsr_step(m_lfsr);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic model_reset();
      m_mode = M_WAIT; m_wait = 0; m_x = 0; m_y = SCR_H;
      m_vx = 0; m_vy = 0; m_score = 0; m_miss = 0;
   endtask

   task automatic model_tick(input int bx, input int by, input int ba, input logic [15:0] r);
      bit hit, exit_b;
      int old_vy;
      case (m_mode)
         M_WAIT: begin
            m_wait++;
            if (m_wait == DELAY) begin
               m_wait = 0;
               m_mode = M_FLY;
               m_x    = 64 + int'(r[8:0]);
               m_y    = SCR_H;
               m_vx   = 1 + int'(r[10:9]);
               if (m_x >= 320) m_vx = -m_vx;
               m_vy   = -(20 + int'(r[15:13]));
            end
         end
         M_FLY, M_FALL: begin
            hit = (m_mode == M_FLY) && (ba != 0) && bx >= m_x && bx < m_x + SIZE
                  && by >= m_y && by < m_y + SIZE;
            old_vy = m_vy;
            m_y += m_vy;
            m_vy += 1;
            m_x += m_vx;
            if (m_x < 0) begin
               m_x = 0; m_vx = -m_vx;
            end else if (m_x > X_MAX) begin
               m_x = X_MAX; m_vx = -m_vx;
            end
            exit_b = old_vy > 0 && m_y >= SCR_H;
            if (hit) begin
               m_mode = M_FALL;
               m_hits++;
               if (m_score < 99) m_score++;
            end else if (exit_b) begin
               if (m_mode == M_FLY) begin
                  m_miss++;
                  m_mode = (m_miss == 3) ? M_OVER : M_WAIT;
               end else begin
                  m_mode = M_WAIT;
               end
            end
         end
         default: ;
      endcase
   endtask

   // One vs pulse with the blade held; the prediction is queued before the pulse.
   task automatic frame(input int bx, input int by, input int ba);
      exp_t e;
      logic [15:0] r;
      blade_x      = 10'(bx);
      blade_y      = 10'(by);
      blade_active = (ba != 0);
      r = lfsr_step(m_lfsr);
      model_tick(bx, by, ba, r);
      e.x = m_x; e.y = m_y;
      e.vis = (m_mode == M_FLY || m_mode == M_FALL) ? 1 : 0;
      e.sl  = (m_mode == M_FALL) ? 1 : 0;
      e.tens = m_score / 10; e.ones = m_score % 10;
      e.miss = m_miss; e.go = (m_mode == M_OVER) ? 1 : 0;
      sb.push_back(e);
      vs = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      vs = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
   endtask

   task automatic frame_rand(input int ba);
      frame(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), ba);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x"},    int'(fruitX), 0);
      check({tag, "_y"},    int'(fruitY), SCR_H);
      check({tag, "_s"},    int'(fruitS), SIZE);
      check({tag, "_vis"},  int'(fruit_visible), 0);
      check({tag, "_sl"},   int'(fruit_sliced), 0);
      check({tag, "_tens"}, int'(score_tens), 0);
      check({tag, "_ones"}, int'(score_ones), 0);
      check({tag, "_miss"}, int'(misses), 0);
      check({tag, "_go"},   int'(game_over), 0);
   endtask

   // Monitor: outputs settle two clocks after each vs falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge vs);
         @(posedge Clk);
         @(posedge Clk);
         @(negedge Clk);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: tick observed with no prediction queued");
         end else begin
            e = sb.pop_front();
            check("fruitX",        int'(fruitX), e.x);
            check("fruitY",        int'(fruitY), e.y);
            check("fruit_visible", int'(fruit_visible), e.vis);
            check("fruit_sliced",  int'(fruit_sliced), e.sl);
            check("score",         int'(score_tens) * 10 + int'(score_ones), e.tens * 10 + e.ones);
            check("misses",        int'(misses), e.miss);
            check("game_over",     int'(game_over), e.go);
         end
      end
   end

   initial begin
      #50000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_reset();
      repeat (3) @(negedge Clk);
      check_reset_vals("por");
      Reset = 1'b0;
      @(negedge Clk);

      // First launch after the idle delay.
      repeat (DELAY - 1) frame(0, 0, 0);
      check("pre_launch_vis", int'(fruit_visible), 0);
      frame(0, 0, 0);
      check("launch_vis", int'(fruit_visible), 1);
      check("launch_y", int'(fruitY), SCR_H);
      check("launch_x_range", int'(fruitX >= 10'd64 && fruitX <= 10'd575), 1);
      check("launch_score", int'(score_tens) * 10 + int'(score_ones), 0);
      check("launch_miss", int'(misses), 0);

      // Free flight, blade idle: ends in a miss.
      n = 0;
      while (m_mode != M_WAIT && n < 200) begin frame_rand(0); n++; end
      if (m_mode != M_WAIT) fail_bound("free_flight");
      check("flight_miss", int'(misses), 1);

      // Single hit, then repeated hits on the cut fruit.
      n = 0;
      while (m_mode == M_WAIT && n < 100) begin frame(0, 0, 0); n++; end
      if (m_mode != M_FLY) fail_bound("hit_launch");
      frame(0, 0, 0);
      frame(m_x + 8, m_y + 8, 1);
      check("hit_sliced", int'(fruit_sliced), 1);
      check("hit_score", int'(score_tens) * 10 + int'(score_ones), 1);
      repeat (4) frame(m_x + 8, m_y + 8, 1);
      check("rehit_score", int'(score_tens) * 10 + int'(score_ones), 1);
      n = 0;
      while (m_mode == M_FALL && n < 200) begin frame(0, 0, 0); n++; end
      if (m_mode != M_WAIT) fail_bound("sliced_exit");
      check("sliced_exit_miss", int'(misses), m_miss);

      // Many launches with random blade activity until past saturation.
      n = 0;
      while (m_hits < 101 && n < 20000) begin
         if (m_mode == M_FLY && (m_vy >= 10 || $urandom_range(0, 7) == 0))
            frame(m_x + 8, m_y + 8, 1);
         else
            frame_rand(int'($urandom_range(0, 1)));
         n++;
      end
      if (m_hits < 101) fail_bound("scoring");
      check("sat_tens", int'(score_tens), 9);
      check("sat_ones", int'(score_ones), 9);

      // Build score 05, then pulse reset mid-flight.
      Reset = 1'b1;
      @(negedge Clk);
      model_reset();
      check_reset_vals("rst_a");
      Reset = 1'b0;
      n = 0;
      while (m_score < 5 && n < 2000) begin
         if (m_mode == M_FLY) frame(m_x + 8, m_y + 8, 1);
         else frame(0, 0, 0);
         n++;
      end
      if (m_score < 5) fail_bound("score_five");
      n = 0;
      while (m_mode != M_FLY && n < 200) begin frame(0, 0, 0); n++; end
      if (m_mode != M_FLY) fail_bound("relaunch_wait");
      repeat (5) frame(0, 0, 0);
      check("pre_reset_score", int'(score_ones), 5);
      check("pre_reset_vis", int'(fruit_visible), 1);
      Reset = 1'b1;
      @(negedge Clk);
      model_reset();
      check_reset_vals("rst_mid");
      Reset = 1'b0;
      repeat (DELAY - 1) frame(0, 0, 0);
      check("relaunch_early", int'(fruit_visible), 0);
      frame(0, 0, 0);
      check("relaunch_vis", int'(fruit_visible), 1);
      check("relaunch_y", int'(fruitY), SCR_H);

      // Three misses lead to game over, which then holds.
      n = 0;
      while (m_mode != M_OVER && n < 1000) begin frame_rand(0); n++; end
      if (m_mode != M_OVER) fail_bound("game_over_wait");
      check("go_flag", int'(game_over), 1);
      check("go_misses", int'(misses), 3);
      repeat (200) frame_rand(int'($urandom_range(0, 1)));
      check("go_vis", int'(fruit_visible), 0);
      check("go_hold", int'(game_over), 1);
      check("go_score", int'(score_tens) * 10 + int'(score_ones), m_score);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
